// File: rtl/bus_region_ctrl.sv
// bus_region_ctrl: 8088 min-mode address latch, region chip-select decode and READY wait-state generator
// Ports: CLK, RESET (sync, active-high), ALE, IOM (1=IO), RD/WR (active-low strobes),
//        BusAddr (multiplexed {A,AD}), Address (latched), CS (one-hot region select),
//        READY (to CPU), BUS_ERR (error pulse, only built with BUSCTL_ERR_EN defined)
module bus_region_ctrl #(
    parameter int                       ADDR_W      = 20,
    parameter int                       NREG        = 4,
    parameter int                       WS_W        = 4,
    parameter logic [NREG*ADDR_W-1:0]   REGION_BASE = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
    parameter logic [NREG*ADDR_W-1:0]   REGION_MASK = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
    parameter logic [NREG-1:0]          REGION_IOM  = 4'b1100,
    parameter logic [NREG*WS_W-1:0]     REGION_WS   = {4'd0, 4'd1, 4'd3, 4'd0}
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALE,
    input  logic              IOM,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] BusAddr,
    output logic [ADDR_W-1:0] Address,
    output logic [NREG-1:0]   CS,
    output logic              READY,
    output logic              BUS_ERR
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_STROBE} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_iom;
    logic [NREG-1:0]   r_cs;
    logic              r_ready;
    logic [WS_W-1:0]   r_cnt;
    logic [NREG-1:0]   w_dec;
    logic [WS_W-1:0]   w_ws;
    logic              w_hit;
    logic              w_strobe;
    // Decode from the latched address/space; the first matching index wins.
    always_comb begin
        w_dec = '0;
        w_ws  = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (!w_hit && ((r_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])
                && (r_iom == REGION_IOM[i])) begin
                w_dec[i] = 1'b1;
                w_ws     = REGION_WS[i*WS_W +: WS_W];
                w_hit    = 1'b1;
            end
    end
    assign w_strobe = !RD || !WR;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_iom   <= 1'b0;
            r_cs    <= '0;
            r_ready <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cs <= '0;
                    if (ALE) begin
                        r_addr  <= BusAddr;
                        r_iom   <= IOM;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_cs <= w_dec;
                    if (ALE) begin
                        r_addr <= BusAddr;
                        r_iom  <= IOM;
                    end else if (w_strobe) begin
                        // An unmatched cycle completes with no wait states.
                        if (w_hit && w_ws != '0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= w_ws - 1'b1;
                            r_ready <= 1'b0;
                        end else
                            r_state <= S_STROBE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_STROBE;
                        r_ready <= 1'b1;
                    end else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_STROBE: begin
                    if (!w_strobe) begin
                        r_state <= S_IDLE;
                        r_cs    <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`ifdef BUSCTL_ERR_EN
    logic r_err;
    always_ff @(posedge CLK)
        r_err <= RESET ? 1'b0 : (r_state == S_ADDR && !ALE && w_strobe && (!w_hit || (!RD && !WR)));
    assign BUS_ERR = r_err;
`else
    assign BUS_ERR = 1'b0;
`endif
    assign Address = r_addr;
    assign CS      = r_cs;
    assign READY   = r_ready;
endmodule

// File: tb/tb_bus_region_ctrl.sv
// tb_bus_region_ctrl: directed and randomized bus cycles checked against a region-table model
module tb_bus_region_ctrl;
    logic        clk;
    logic        rst;
    logic        ale;
    logic        iom;
    logic        rd;
    logic        wr;
    logic [19:0] bus_addr;
    logic [19:0] address;
    logic [3:0]  cs;
    logic        ready;
    logic        bus_err;
    int          checks;
    int          passed;
    logic [19:0] base [4] = '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
    logic [19:0] mask [4] = '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
    logic        io_sp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          ws [4] = '{0, 3, 1, 0};
    logic [19:0] picks [9] = '{20'h01234, 20'h80010, 20'h0FF05, 20'h01C80, 20'h00000,
                               20'h7FFFF, 20'hFFFFF, 20'h01DFF, 20'h0FF0F};
    bus_region_ctrl dut (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr), .BusAddr(bus_addr),
        .Address(address), .CS(cs), .READY(ready), .BUS_ERR(bus_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask
    function automatic int region(input logic [19:0] a, input logic io);
        for (int i = 0; i < 4; i++)
            if (((a & mask[i]) == base[i]) && io == io_sp[i]) return i;
        return -1;
    endfunction
    task automatic bus_cycle(input logic [19:0] a, input logic io, input logic r, input logic w,
                             input logic two, input logic [19:0] a0);
        int         ri;
        int         n;
        logic [3:0] ecs;
        logic       eerr;
        ri  = region(a, io);
        n   = (ri < 0) ? 0 : ws[ri];
        ecs = '0;
        if (ri >= 0) ecs[ri] = 1'b1;
`ifdef BUSCTL_ERR_EN
        eerr = (ri < 0) || (!r && !w);
`else
        eerr = 1'b0;
`endif
        ale = 1'b1;
        iom = io;
        bus_addr = two ? a0 : a;
        tick();
        if (two) begin
            bus_addr = a;
            tick();
        end
        chk("addr", 32'(address), 32'(a));
        ale = 1'b0;
        bus_addr = 20'($urandom);
        iom = 1'($urandom);
        tick();
        chk("cs", 32'(cs), 32'(ecs));
        chk("ready_pre", 32'(ready), 32'd1);
        rd = r;
        wr = w;
        tick();
        chk("err", 32'(bus_err), 32'(eerr));
        chk("ready_t", 32'(ready), 32'(n == 0));
        for (int k = 1; k <= n; k++) begin
            tick();
            chk("ready_ws", 32'(ready), 32'(k == n));
            chk("cs_hold", 32'(cs), 32'(ecs));
        end
        tick();
        chk("ready_end", 32'(ready), 32'd1);
        chk("err_clr", 32'(bus_err), 32'd0);
        rd = 1'b1;
        wr = 1'b1;
        tick();
        tick();
        chk("cs_idle", 32'(cs), 32'd0);
    endtask
    initial begin
        int sel;
        logic [19:0] a;
        checks = 0;
        passed = 0;
        rst = 1'b1;
        ale = 1'b0;
        iom = 1'b0;
        rd = 1'b1;
        wr = 1'b1;
        bus_addr = 20'hABCDE;
        tick();
        tick();
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_err", 32'(bus_err), 32'd0);
        rst = 1'b0;
        tick();
        bus_cycle(20'h01234, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        bus_cycle(20'h80010, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0);
        ale = 1'b1;
        iom = 1'b0;
        bus_addr = 20'h80010;
        tick();
        ale = 1'b0;
        tick();
        chk("mid_cs", 32'(cs), 32'h2);
        wr = 1'b0;
        tick();
        chk("mid_w1", 32'(ready), 32'd0);
        tick();
        chk("mid_w2", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_cs0", 32'(cs), 32'd0);
        chk("mid_addr", 32'(address), 32'd0);
        rst = 1'b0;
        wr = 1'b1;
        tick();
        bus_cycle(20'h0FF05, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
        bus_cycle(20'h01C80, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
        bus_cycle(20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h0);
        bus_cycle(20'h0FF05, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
        bus_cycle(20'h80001, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00001);
        for (int it = 0; it < 30; it++) begin
            a = ($urandom_range(0, 3) == 0) ? 20'($urandom) : picks[$urandom_range(0, 8)];
            sel = $urandom_range(0, 2);
            bus_cycle(a, 1'($urandom), 1'(sel == 1), 1'(sel == 0), 1'($urandom), 20'($urandom));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
